traffic_light_ctrl: RTL
=======================

// Module: traffic_light_ctrl
// PURPOSE
//  Two-road traffic-light controller that consumes the 1-in-N enable pulse from the
//  divide-by-N tick generator directly upstream (tick = its y output).
//  All timing is in ticks, not clocks; between ticks the block holds state.
//  Drives lights for road A and road B from sensors ta/tb, with a minimum green and
//  a fixed yellow duration.
// PARAMETERS
//  MIN_GREEN     3  minimum ticks a road stays green before it may yield (>=1)
//  YELLOW_TICKS  2  ticks a road shows yellow before the other road goes green (>=1)
// PORTS
//  clk      in   1  single clock, rising edge
//  reset    in   1  synchronous, active-high
//  tick     in   1  enable pulse from the clock divider; may be held high (1 tick/cycle)
//  ta       in   1  traffic present on road A (sampled only on tick cycles)
//  tb       in   1  traffic present on road B (sampled only on tick cycles)
//  la       out  2  road A light: GREEN=2'b00, YELLOW=2'b01, RED=2'b10
//  lb       out  2  road B light, same encoding
//  phase    out  2  current state, for debug/bench
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - States: A_GRN, A_YEL, B_GRN, B_YEL (phase = 0..3 in that order).
//  - Outputs are Moore, decoded from state:
//    A_GRN: la=GRN lb=RED; A_YEL: la=YEL lb=RED;
//    B_GRN: la=RED lb=GRN; B_YEL: la=RED lb=YEL.
//  - Reset: state=A_GRN, dwell=0, so la=2'b00, lb=2'b10, phase=0 the cycle after reset.
//    Reset has priority over tick.
//  - dwell: tick counter, $clog2(max(MIN_GREEN,YELLOW_TICKS)+1) bits.
//    Cleared on every state change, otherwise incremented on tick and saturating.
//  - Transitions are evaluated only when tick=1, using the pre-increment dwell value:
//    A_GRN -> A_YEL : !ta && dwell >= MIN_GREEN-1
//    A_YEL -> B_GRN : dwell == YELLOW_TICKS-1
//    B_GRN -> B_YEL : !tb && dwell >= MIN_GREEN-1
//    B_YEL -> A_GRN : dwell == YELLOW_TICKS-1
//  - tick=0: state, dwell and outputs hold; ta/tb are ignored.
//  - Latency: lights change on the clock edge that samples the qualifying tick.
//    The new value is visible the following cycle.
//  - Green lasts >= MIN_GREEN ticks; extended indefinitely while own sensor is high,
//    even if the other sensor is also high.
//  - Yellow lasts exactly YELLOW_TICKS ticks; sensors are ignored in yellow states.
//  - Never two non-RED lights at once; an illegal state encoding recovers to A_GRN.
//  - Reset mid-phase (e.g. in B_YEL) returns to A_GRN/dwell=0 on the next edge.
// STRUCTURE
//  - Package traffic_pkg: light_t enum (GREEN/YELLOW/RED, 2 bits) and state_t enum
//    (A_GRN/A_YEL/B_GRN/B_YEL, 2 bits).
//  - Sub-module tick_dwell_timer: saturating counter with enable (tick) and clear
//    (state change), parameterised on width.
//  - Top: state register, next-state logic, output decode.
// TESTING (MIN_GREEN=3, YELLOW_TICKS=2, tick every 3rd cycle unless noted)
//  1. Assert reset 2 cycles -> la=00, lb=10, phase=0; outputs hold with tick=0 for
//     10 cycles.
//  2. ta=0, tb=0 -> A_GRN after 3rd tick, A_YEL for 2 ticks, B_GRN, then B_YEL after
//     3 more ticks; full cycle = 10 ticks = 30 clocks.
//  3. ta=1 held 20 ticks -> la stays 00; drop ta -> A_YEL on next tick (dwell >= 2).
//  4. ta=1, tb=1 -> A green held; sensors toggled during A_YEL -> yellow still exactly
//     2 ticks.
//  5. tick held high -> timings in clocks equal timings in ticks (A_GRN 3 clocks,
//     A_YEL 2 clocks).
//  6. reset asserted together with tick while in B_YEL -> next cycle la=00, lb=10,
//     phase=0; never la,lb both != 10.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared light/state encodings and the state-to-lights decode
//               for the two-road traffic-light controller.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        A_GRN = 2'd0,
        A_YEL = 2'd1,
        B_GRN = 2'd2,
        B_YEL = 2'd3
    } state_t;

    typedef struct packed {
        light_t a;
        light_t b;
    } lights_t;

    // Unknown encodings decode to all-red so two roads can never both be open.
    function automatic lights_t lights_of(input state_t s);
        lights_t l;
        l.a = RED;
        l.b = RED;
        case (s)
            A_GRN:   l.a = GREEN;
            A_YEL:   l.a = YELLOW;
            B_GRN:   l.b = GREEN;
            B_YEL:   l.b = YELLOW;
            default: ;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : tick_dwell_timer
// Description : Saturating tick counter with enable and synchronous clear.
//               Clear wins over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_dwell_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Two-road traffic-light controller advancing on divider ticks,
//               with minimum green, sensor-extended green and fixed yellow.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = 3,
    parameter int YELLOW_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ta,
    input  logic       tb,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic [1:0] phase
);

    localparam int c_dwell_max = (MIN_GREEN > YELLOW_TICKS) ? MIN_GREEN : YELLOW_TICKS;
    localparam int c_dwell_w   = $clog2(c_dwell_max + 1);
    localparam logic [c_dwell_w-1:0] c_grn_last = c_dwell_w'(MIN_GREEN - 1);
    localparam logic [c_dwell_w-1:0] c_yel_last = c_dwell_w'(YELLOW_TICKS - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 w_change;
    logic [c_dwell_w-1:0] w_dwell;
    lights_t              w_lights;
    light_t               r_la;
    light_t               r_lb;
    logic [1:0]           r_phase;

    tick_dwell_timer #(
        .WIDTH (c_dwell_w)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .clr   (w_change),
        .count (w_dwell)
    );

    // Decisions use the dwell value before this tick's increment.
    always_comb begin
        w_next = r_state;
        case (r_state)
            A_GRN: if (tick && !ta && (w_dwell >= c_grn_last)) w_next = A_YEL;
            A_YEL: if (tick && (w_dwell == c_yel_last))         w_next = B_GRN;
            B_GRN: if (tick && !tb && (w_dwell >= c_grn_last)) w_next = B_YEL;
            B_YEL: if (tick && (w_dwell == c_yel_last))         w_next = A_GRN;
            default:                                             w_next = A_GRN;
        endcase
    end

    assign w_change = (w_next != r_state);
    assign w_lights = lights_of(w_next);

    // Lights and phase are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= A_GRN;
            r_la    <= GREEN;
            r_lb    <= RED;
            r_phase <= 2'd0;
        end else begin
            r_state <= w_next;
            r_la    <= w_lights.a;
            r_lb    <= w_lights.b;
            r_phase <= w_next;
        end
    end

    assign la    = r_la;
    assign lb    = r_lb;
    assign phase = r_phase;

endmodule
`default_nettype wire
